fpu_sequencer: RTL and testbench

- Multi-cycle issue/completion controller for the FP add/sub/mul/div datapath.
- Accepts F-type instructions from main decode and starts the FP core.
- Counts the op latency, stalls dependent or overlapping instructions, and arbitrates the single FP register-file write port against FP loads.
- Sits between main decode, the FP datapath and the FP register file.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_sequencer.sv | 103 ++++++++++
 tb/tb_fpu_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and default latencies
// for the FP issue/completion sequencer.
package fpu_pkg;

  typedef enum logic [1:0] {
    FADD = 2'd0,
    FSUB = 2'd1,
    FMUL = 2'd2,
    FDIV = 2'd3
  } fpu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } fpu_state_t;

  localparam int ADD_LAT_D = 3;
  localparam int MUL_LAT_D = 4;
  localparam int DIV_LAT_D = 12;

endpackage

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issues FP ops, counts latency,
// stalls hazards and arbitrates the FP write port.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_D,
  parameter int MUL_LAT = MUL_LAT_D,
  parameter int DIV_LAT = DIV_LAT_D,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic [3:0] fpu_control,
  input  logic [4:0] fd,
  input  logic       src_valid,
  input  logic [4:0] fs,
  input  logic [4:0] ft,
  input  logic       flush,
  input  logic       ld_fp_wr,
  output logic       stall,
  output logic       fpu_start,
  output logic [1:0] fpu_op,
  output logic       fp_regwrite,
  output logic [4:0] fp_wa,
  output logic       busy,
  output logic       illegal
);

  fpu_state_t       state;
  fpu_op_t          op_q;
  logic [4:0]       fd_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_m1;
  logic             start_q;
  logic             ill_q;
  logic             legal;
  logic             raw;
  logic             accept;

  // Hazard detection and accept decision
  always_comb begin
    legal  = (fpu_control[3:2] == 2'b00);
    raw    = src_valid && (state != IDLE) &&
             ((fs == fd_q) || (ft == fd_q));
    stall  = (issue && state == EXEC) || raw ||
             (issue && state == WB && ld_fp_wr);
    accept = issue && legal && !stall && !flush &&
             (state == IDLE || state == WB);
  end

  // Initial countdown value for the issuing op
  always_comb begin
    lat_m1 = '0;
    unique case (fpu_op_t'(fpu_control[1:0]))
      FADD, FSUB: lat_m1 = CNT_W'(ADD_LAT - 1);
      FMUL:       lat_m1 = CNT_W'(MUL_LAT - 1);
      FDIV:       lat_m1 = CNT_W'(DIV_LAT - 1);
      default:    lat_m1 = '0;
    endcase
  end

  // Sequencer state, latency counter and op latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= FADD;
      fd_q    <= '0;
      cnt     <= '0;
      start_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      start_q <= accept;
      ill_q   <= issue && !legal && !stall;
      if (accept) begin
        op_q <= fpu_op_t'(fpu_control[1:0]);
        fd_q <= fd;
        cnt  <= lat_m1;
      end
      unique case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          if (flush)
            state <= IDLE;
          else if (cnt == '0)
            state <= WB;
          else
            cnt <= cnt - 1'b1;
        end
        WB: if (!ld_fp_wr) state <= accept ? EXEC : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign fpu_start   = start_q;
  assign illegal     = ill_q;
  assign busy        = (state != IDLE);
  assign fpu_op      = op_q;
  assign fp_wa       = fd_q;
  assign fp_regwrite = (state == WB) && !ld_fp_wr;

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: directed bench for the
// FP issue/completion sequencer.
module tb_fpu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       issue = 1'b0;
  logic [3:0] fpu_control = '0;
  logic [4:0] fd = '0;
  logic       src_valid = 1'b0;
  logic [4:0] fs = '0;
  logic [4:0] ft = '0;
  logic       flush = 1'b0;
  logic       ld_fp_wr = 1'b0;
  logic       stall;
  logic       fpu_start;
  logic [1:0] fpu_op;
  logic       fp_regwrite;
  logic [4:0] fp_wa;
  logic       busy;
  logic       illegal;

  int total = 0;
  int bad = 0;
  int sc;
  int wr_seen;

  fpu_sequencer dut (
    .clk(clk),
    .reset(reset),
    .issue(issue),
    .fpu_control(fpu_control),
    .fd(fd),
    .src_valid(src_valid),
    .fs(fs),
    .ft(ft),
    .flush(flush),
    .ld_fp_wr(ld_fp_wr),
    .stall(stall),
    .fpu_start(fpu_start),
    .fpu_op(fpu_op),
    .fp_regwrite(fp_regwrite),
    .fp_wa(fp_wa),
    .busy(busy),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic drv(input logic       i,
                     input logic [3:0] c,
                     input logic [4:0] d,
                     input logic       sv,
                     input logic [4:0] s,
                     input logic [4:0] t);
    issue       = i;
    fpu_control = c;
    fd          = d;
    src_valid   = sv;
    fs          = s;
    ft          = t;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_start"}, int'(fpu_start), 0);
    chk({tag, "_op"}, int'(fpu_op), 0);
    chk({tag, "_wr"}, int'(fp_regwrite), 0);
    chk({tag, "_wa"}, int'(fp_wa), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ill"}, int'(illegal), 0);
  endtask

  initial begin
    #2;
    chk_all_zero("rst");
    nxt;
    nxt;
    reset = 1'b1;
    nxt;

    // reset in the middle of a mul
    drv(1, 4'd2, 5'd4, 0, 0, 0);
    #1;
    chk("t1_stall", int'(stall), 0);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_start", int'(fpu_start), 1);
    chk("t1_busy", int'(busy), 1);
    nxt;
    reset = 1'b0;
    #1;
    chk_all_zero("t1_rst");
    nxt;
    nxt;
    reset = 1'b1;
    wr_seen = 0;
    repeat (6) begin
      nxt;
      if (fp_regwrite) wr_seen = 1;
    end
    chk("t1_nowr", wr_seen, 0);
    chk("t1_idle", int'(busy), 0);

    // basic add, fd=7, latency
    drv(1, 4'd0, 5'd7, 0, 0, 0);
    #1;
    chk("t2_stall", int'(stall), 0);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("t2_start1", int'(fpu_start), 1);
    chk("t2_busy1", int'(busy), 1);
    chk("t2_op", int'(fpu_op), 0);
    nxt;
    chk("t2_start2", int'(fpu_start), 0);
    nxt;
    chk("t2_wr3", int'(fp_regwrite), 0);
    nxt;
    chk("t2_wr4", int'(fp_regwrite), 1);
    chk("t2_wa4", int'(fp_wa), 7);
    nxt;
    chk("t2_busy5", int'(busy), 0);
    chk("t2_wr5", int'(fp_regwrite), 0);

    // div fd=3 then dependent add fs=3
    drv(1, 4'd3, 5'd3, 0, 0, 0);
    #1;
    chk("t3_stall0", int'(stall), 0);
    nxt;
    drv(1, 4'd0, 5'd8, 1, 5'd3, 5'd0);
    #1;
    chk("t3_start", int'(fpu_start), 1);
    chk("t3_op", int'(fpu_op), 3);
    sc = 0;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) nxt;
      if (stall) sc++;
      if (i == 11) chk("t3_wr_ex", int'(fp_regwrite), 0);
      if (i == 12) begin
        chk("t3_wr", int'(fp_regwrite), 1);
        chk("t3_wa", int'(fp_wa), 3);
      end
    end
    chk("t3_stallcnt", sc, 13);
    nxt;
    chk("t3_stall_idle", int'(stall), 0);
    chk("t3_busy_idle", int'(busy), 0);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("t3_start2", int'(fpu_start), 1);
    chk("t3_op2", int'(fpu_op), 0);
    chk("t3_wa2", int'(fp_wa), 8);
    nxt;
    nxt;
    nxt;
    chk("t3_wr2", int'(fp_regwrite), 1);
    chk("t3_wa2wb", int'(fp_wa), 8);
    nxt;
    chk("t3_done", int'(busy), 0);

    // mul fd=2, independent sub taken in WB
    drv(1, 4'd2, 5'd2, 0, 0, 0);
    #1;
    nxt;
    drv(1, 4'd1, 5'd10, 1, 5'd5, 5'd6);
    #1;
    sc = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt;
      if (stall) sc++;
    end
    chk("t4_stallcnt", sc, 4);
    nxt;
    chk("t4_stall_wb", int'(stall), 0);
    chk("t4_wr", int'(fp_regwrite), 1);
    chk("t4_wa", int'(fp_wa), 2);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("t4_start", int'(fpu_start), 1);
    chk("t4_busy", int'(busy), 1);
    chk("t4_op", int'(fpu_op), 1);
    chk("t4_wa2", int'(fp_wa), 10);
    nxt;
    nxt;
    nxt;
    chk("t4_wr2", int'(fp_regwrite), 1);
    chk("t4_wa2wb", int'(fp_wa), 10);
    nxt;
    chk("t4_done", int'(busy), 0);

    // load wins the write port
    drv(1, 4'd0, 5'd9, 0, 0, 0);
    #1;
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    nxt;
    nxt;
    nxt;
    ld_fp_wr = 1'b1;
    drv(1, 4'd0, 5'd11, 0, 0, 0);
    #1;
    chk("t5_wr_held", int'(fp_regwrite), 0);
    chk("t5_stall", int'(stall), 1);
    chk("t5_busy", int'(busy), 1);
    nxt;
    ld_fp_wr = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("t5_wr", int'(fp_regwrite), 1);
    chk("t5_wa", int'(fp_wa), 9);
    chk("t5_nostart", int'(fpu_start), 0);
    nxt;
    chk("t5_done", int'(busy), 0);

    // flush in WB still writes, drops issue
    drv(1, 4'd0, 5'd13, 0, 0, 0);
    #1;
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    nxt;
    nxt;
    nxt;
    flush = 1'b1;
    drv(1, 4'd0, 5'd14, 0, 0, 0);
    #1;
    chk("t6_wr", int'(fp_regwrite), 1);
    chk("t6_wa", int'(fp_wa), 13);
    nxt;
    flush = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("t6_nostart", int'(fpu_start), 0);
    chk("t6_idle", int'(busy), 0);

    // flush during div EXEC
    drv(1, 4'd3, 5'd12, 0, 0, 0);
    #1;
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    nxt;
    flush = 1'b1;
    #1;
    nxt;
    flush = 1'b0;
    #1;
    chk("t7_idle", int'(busy), 0);
    wr_seen = 0;
    repeat (14) begin
      nxt;
      if (fp_regwrite) wr_seen = 1;
    end
    chk("t7_nowr", wr_seen, 0);

    // illegal op 0101
    drv(1, 4'd5, 5'd1, 0, 0, 0);
    #1;
    chk("t8_stall", int'(stall), 0);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("t8_ill", int'(illegal), 1);
    chk("t8_busy", int'(busy), 0);
    chk("t8_start", int'(fpu_start), 0);
    nxt;
    chk("t8_ill_off", int'(illegal), 0);
    chk("t8_busy2", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
